// File: rtl/apb_master_bridge_if.sv
// Bundle of the command, response and APB signals around the APB master bridge.
// The master modport is the bridge's view. The slave modport is the view of the requester and peripheral side.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB3 bus
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: turns one valid/ready command into one SETUP/ACCESS transfer.
// It returns the read data, the slave error and the timeout status on a valid/ready response channel.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_master_bridge_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_reg,       state_next;
  logic [CNT_W-1:0]      cnt_reg,         cnt_next;
  logic [ADDR_WIDTH-1:0] paddr_reg,       paddr_next;
  logic                  pwrite_reg,      pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata_reg,      pwdata_next;
  logic                  psel_reg,        psel_next;
  logic                  penable_reg,     penable_next;
  logic                  rsp_valid_reg,   rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg,   rsp_rdata_next;
  logic                  rsp_err_reg,     rsp_err_next;
  logic                  rsp_timeout_reg, rsp_timeout_next;

  logic timeout_hit;

  // The counter holds the number of low-PREADY ACCESS cycles already seen.
  // The cycle being evaluated is therefore the TIMEOUT_CYCLES-th one when cnt == TIMEOUT_CYCLES-1.
  assign timeout_hit = TO_EN && (cnt_reg == CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      paddr_reg       <= '0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      paddr_reg       <= paddr_next;
      pwrite_reg      <= pwrite_next;
      pwdata_reg      <= pwdata_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    paddr_next       = paddr_reg;
    pwrite_next      = pwrite_reg;
    pwdata_next      = pwdata_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;

    case (state_reg)
      IDLE: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        if (bus.cmd_valid) begin
          paddr_next  = bus.cmd_addr;
          pwrite_next = bus.cmd_write;
          pwdata_next = bus.cmd_wdata;
          psel_next   = 1'b1;
          state_next  = SETUP;
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        cnt_next     = '0;
        state_next   = ACCESS;
      end

      ACCESS: begin
        // PREADY takes priority over a timeout that would fire in the same cycle.
        if (bus.PREADY) begin
          rsp_rdata_next   = pwrite_reg ? '0 : bus.PRDATA;
          rsp_err_next     = bus.PSLVERR;
          rsp_timeout_next = 1'b0;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          state_next       = RESP;
        end else begin
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
          end
          if (timeout_hit) begin
            rsp_rdata_next   = '0;
            rsp_err_next     = 1'b1;
            rsp_timeout_next = 1'b1;
            psel_next        = 1'b0;
            penable_next     = 1'b0;
            rsp_valid_next   = 1'b1;
            state_next       = RESP;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = (state_reg == IDLE);
  assign bus.PADDR       = paddr_reg;
  assign bus.PSEL        = psel_reg;
  assign bus.PENABLE     = penable_reg;
  assign bus.PWRITE      = pwrite_reg;
  assign bus.PWDATA      = pwdata_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench plays both the command requester and the APB slave.
// Each transfer is scored against hand-computed timing and data.
module tb_apb_master_bridge;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   failures;

  apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer. wait_n is the number of ACCESS cycles with PREADY low; a negative value means forever.
  // hold is the number of cycles rsp_ready is kept low once the response is up.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int wait_n, input logic [31:0] prd, input logic perr, input int hold,
                      output int en_cycles, output int sel_cycles, output int lat,
                      output logic [31:0] rd, output logic err, output logic to,
                      output logic [31:0] pwd);
    int   c;
    int   acc;
    logic done;
    logic stable_ok;
    en_cycles  = 0;
    sel_cycles = 0;
    lat        = 0;
    acc        = 0;
    c          = 0;
    done       = 1'b0;
    stable_ok  = 1'b1;
    pwd        = '0;
    check("cmd_ready_at_accept", 64'(bus.cmd_ready), 64'd1);
    bus.rsp_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_wdata = wd;
    while (!done && c < 100) begin
      @(negedge PCLK);
      c++;
      if (c == 1) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) begin
        done        = 1'b1;
        lat         = c;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
      end else begin
        if (bus.PSEL) begin
          sel_cycles++;
          if (bus.PADDR !== addr || bus.PWRITE !== wr) stable_ok = 1'b0;
        end
        if (bus.PENABLE) en_cycles++;
        if (bus.PSEL && bus.PENABLE) begin
          pwd         = bus.PWDATA;
          bus.PREADY  = (wait_n >= 0) && (acc >= wait_n);
          bus.PRDATA  = bus.PREADY ? prd : 32'h5A5A5A5A;
          bus.PSLVERR = bus.PREADY ? perr : 1'b0;
          acc++;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'b0;
        end
      end
    end
    check("rsp_within_bound", 64'(done), 64'd1);
    check("addr_dir_stable", 64'(stable_ok), 64'd1);
    check("psel_low_in_rsp", 64'(bus.PSEL), 64'd0);
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    to  = bus.rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      @(negedge PCLK);
      check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rsp_rdata", 64'(bus.rsp_rdata), 64'(rd));
      check("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("hold_psel", 64'(bus.PSEL), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    check("rsp_valid_dropped", 64'(bus.rsp_valid), 64'd0);
    check("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
    $display("xfer addr=0x%08h wr=%0d lat=%0d sel=%0d en=%0d rdata=0x%08h err=%0d to=%0d",
             addr, wr, lat, sel_cycles, en_cycles, rd, err, to);
  endtask

  int          en;
  int          sel;
  int          lat;
  logic [31:0] rd;
  logic [31:0] pwd;
  logic        err;
  logic        to;

  initial begin
    checks        = 0;
    failures      = 0;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    repeat (2) @(negedge PCLK);
    check("rst_psel", 64'(bus.PSEL), 64'd0);
    check("rst_penable", 64'(bus.PENABLE), 64'd0);
    check("rst_pwrite", 64'(bus.PWRITE), 64'd0);
    check("rst_paddr", 64'(bus.PADDR), 64'd0);
    check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);

    // zero-wait write then read-back of the same word
    xfer(32'h8, 1'b1, 32'hDEADBEEF, 0, 32'h12345678, 1'b0, 0, en, sel, lat, rd, err, to, pwd);
    check("wr_pwdata", 64'(pwd), 64'hDEADBEEF);
    check("wr_sel_cycles", 64'(sel), 64'd2);
    check("wr_en_cycles", 64'(en), 64'd1);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_rdata_zero", 64'(rd), 64'd0);
    check("wr_err", 64'(err), 64'd0);

    xfer(32'h8, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 0, en, sel, lat, rd, err, to, pwd);
    check("rd_sel_cycles", 64'(sel), 64'd2);
    check("rd_en_cycles", 64'(en), 64'd1);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_rdata", 64'(rd), 64'hDEADBEEF);
    check("rd_err", 64'(err), 64'd0);

    // three wait states
    xfer(32'h4, 1'b0, 32'h0, 3, 32'h0000CAFE, 1'b0, 0, en, sel, lat, rd, err, to, pwd);
    check("ws_en_cycles", 64'(en), 64'd4);
    check("ws_sel_cycles", 64'(sel), 64'd5);
    check("ws_latency", 64'(lat), 64'd6);
    check("ws_rdata", 64'(rd), 64'h0000CAFE);
    check("ws_timeout", 64'(to), 64'd0);

    // slave error
    xfer(32'h40, 1'b0, 32'h0, 0, 32'h0, 1'b1, 0, en, sel, lat, rd, err, to, pwd);
    check("slverr_err", 64'(err), 64'd1);
    check("slverr_timeout", 64'(to), 64'd0);
    check("slverr_rdata", 64'(rd), 64'd0);

    // PREADY stuck low: abort after 16 ACCESS cycles
    xfer(32'h44, 1'b0, 32'h0, -1, 32'hFFFFFFFF, 1'b0, 0, en, sel, lat, rd, err, to, pwd);
    check("to_en_cycles", 64'(en), 64'd16);
    check("to_latency", 64'(lat), 64'd18);
    check("to_err", 64'(err), 64'd1);
    check("to_timeout", 64'(to), 64'd1);
    check("to_rdata", 64'(rd), 64'd0);

    // PREADY rises on the 16th ACCESS cycle: completion beats the timeout
    xfer(32'h48, 1'b0, 32'h0, 15, 32'h600DF00D, 1'b0, 0, en, sel, lat, rd, err, to, pwd);
    check("edge_en_cycles", 64'(en), 64'd16);
    check("edge_timeout", 64'(to), 64'd0);
    check("edge_err", 64'(err), 64'd0);
    check("edge_rdata", 64'(rd), 64'h600DF00D);

    // response back-pressure for five cycles
    xfer(32'h4, 1'b0, 32'h0, 0, 32'h13579BDF, 1'b0, 5, en, sel, lat, rd, err, to, pwd);
    check("bp_rdata", 64'(rd), 64'h13579BDF);

    // reset during the second ACCESS cycle
    bus.PREADY    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h10;
    bus.cmd_write = 1'b0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("mid_penable_before_rst", 64'(bus.PENABLE), 64'd1);
    #1 PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", 64'(bus.PSEL), 64'd0);
    check("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("post_rst_psel", 64'(bus.PSEL), 64'd0);

    xfer(32'h20, 1'b1, 32'h0BADF00D, 0, 32'h0, 1'b0, 0, en, sel, lat, rd, err, to, pwd);
    check("post_rst_wr_pwdata", 64'(pwd), 64'h0BADF00D);
    check("post_rst_wr_latency", 64'(lat), 64'd3);
    check("post_rst_wr_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
